// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and a
// small helper that tells whether a state may accept a new start request.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // A new operation may only begin when no addition is in flight.
    function automatic logic canAccept(input state_t s);
        return (s == IDLE) || (s == DONE);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational one-bit full adder; the only arithmetic in the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic w_halfSum;

    // Sum and carry of a single bit position.
    always_comb begin
        w_halfSum = a ^ b;
        s         = w_halfSum ^ cin;
        co        = (a & b) | (cin & w_halfSum);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are loaded in parallel, added LSB-first
// through one full-adder cell with a carry flop, and the parallel result is
// published with a one-cycle done pulse. The previous result stays on sum/cout
// while the next addition runs.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shiftA;
    logic [WIDTH-1:0] r_shiftB;
    logic [WIDTH-1:0] r_partial;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    state_t           w_nextState;
    logic             w_accept;
    logic             w_lastBit;
    logic             w_cellSum;
    logic             w_cellCarry;

    fa_cell u_faCell (
        .a   (r_shiftA[0]),
        .b   (r_shiftB[0]),
        .cin (r_carry),
        .s   (w_cellSum),
        .co  (w_cellCarry)
    );

    // Decide the next FSM state; start is only honoured outside RUN.
    always_comb begin
        w_accept    = start && canAccept(r_state);
        w_lastBit   = (r_state == RUN) && (r_count == LAST);
        w_nextState = r_state;
        case (r_state)
            IDLE:    w_nextState = w_accept ? RUN : IDLE;
            RUN:     w_nextState = w_lastBit ? DONE : RUN;
            DONE:    w_nextState = w_accept ? RUN : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // State, datapath shift registers, carry flop and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shiftA  <= '0;
            r_shiftB  <= '0;
            r_partial <= '0;
            r_carry   <= 1'b0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_busy  <= (w_nextState == RUN);
            r_done  <= w_lastBit;

            if (w_accept) begin
                r_shiftA  <= a;
                r_shiftB  <= b;
                r_carry   <= cin;
                r_count   <= '0;
                r_partial <= '0;
            end else if (r_state == RUN) begin
                r_shiftA  <= {1'b0, r_shiftA[WIDTH-1:1]};
                r_shiftB  <= {1'b0, r_shiftB[WIDTH-1:1]};
                r_carry   <= w_cellCarry;
                r_partial <= {w_cellSum, r_partial[WIDTH-1:1]};
                if (w_lastBit) begin
                    r_count <= '0;
                    r_sum   <= {w_cellSum, r_partial[WIDTH-1:1]};
                    r_cout  <= w_cellCarry;
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
